// File: rtl/ets_frame_tagger.sv
`default_nettype none
// ============================================================================
// Module      : ets_frame_tagger
// Description : Wraps ETS sample frames with a {MAGIC, seq} header and a
//               {ovf, count} trailer; over-length frames are truncated and
//               their tail is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module ets_frame_tagger #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [15:0] MAGIC     = 16'hE75A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [3:0]  m_axis_tkeep,
    output logic [15:0] frame_seq,
    output logic [15:0] overflow_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

    state_t      r_state;
    logic [15:0] r_word_cnt;
    logic        r_ovf_flag;
    logic        r_discard_pending;
    logic [15:0] r_frame_seq;
    logic [15:0] r_overflow_count;

    logic w_out_free;
    logic w_s_accept;
    logic w_cnt_full;

    // The output register may take a new beat when empty or draining this cycle.
    assign w_out_free    = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ((r_state == ST_PAYLOAD) && w_out_free) || (r_state == ST_DISCARD);
    assign w_s_accept    = s_axis_tvalid && s_axis_tready;
    assign w_cnt_full    = ({1'b0, r_word_cnt} + 17'd1) == c_MAX_WORDS;

    assign m_axis_tkeep   = 4'b1111;
    assign frame_seq      = r_frame_seq;
    assign overflow_count = r_overflow_count;
    assign busy           = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_word_cnt        <= 16'd0;
            r_ovf_flag        <= 1'b0;
            r_discard_pending <= 1'b0;
            r_frame_seq       <= 16'd0;
            r_overflow_count  <= 16'd0;
            m_axis_tdata      <= 32'd0;
            m_axis_tvalid     <= 1'b0;
            m_axis_tlast      <= 1'b0;
        end else begin
            if (w_out_free) begin
                m_axis_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable && s_axis_tvalid && w_out_free) begin
                        m_axis_tdata  <= {MAGIC, r_frame_seq};
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        r_word_cnt    <= 16'd0;
                        r_state       <= ST_PAYLOAD;
                    end
                end

                ST_PAYLOAD: begin
                    if (w_s_accept) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        r_word_cnt    <= r_word_cnt + 16'd1;
                        // A tlast on the final permitted word is a normal frame.
                        if (s_axis_tlast) begin
                            r_ovf_flag <= 1'b0;
                            r_state    <= ST_TRAILER;
                        end else if (w_cnt_full) begin
                            r_ovf_flag        <= 1'b1;
                            r_discard_pending <= 1'b1;
                            r_state           <= ST_TRAILER;
                        end
                    end
                end

                ST_TRAILER: begin
                    if (w_out_free) begin
                        m_axis_tdata  <= {r_ovf_flag, 15'd0, r_word_cnt};
                        m_axis_tlast  <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        r_frame_seq   <= r_frame_seq + 16'd1;
                        r_state       <= r_discard_pending ? ST_DISCARD : ST_IDLE;
                    end
                end

                ST_DISCARD: begin
                    if (w_s_accept && s_axis_tlast) begin
                        r_discard_pending <= 1'b0;
                        if (r_overflow_count != 16'hFFFF) begin
                            r_overflow_count <= r_overflow_count + 16'd1;
                        end
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
